// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the RV32I/RV64I immediate of each
// instruction and holds it in a main output register backed by a one-entry skid register.
module imm_gen_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal,
  output logic [1:0]      o_dbg_state
);

  // Handshake: a word moves upstream->stage when i_valid && o_ready and stage->downstream
  // when o_valid && i_ready; while o_valid && !i_ready every output holds its value.

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_OP32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_J    = 3'd4;
  localparam logic [2:0] T_U    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, dec;
  logic   ready_q;
  logic   in_xfer, out_xfer;
  logic   load_main_in, load_main_skid, load_skid;
  logic   is_shift;
  logic [5:0] shamt;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  assign is_shift = (i_instr[14:12] == 3'b001) || (i_instr[14:12] == 3'b101);
  assign shamt    = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

  always_comb begin
    dec          = '0;
    dec.instr    = i_instr;
    dec.imm_type = T_NONE;
    case (i_instr[6:0])
      OPC_LOAD, OPC_JALR: begin
        dec.imm      = sext({{20{i_instr[31]}}, i_instr[31:20]});
        dec.imm_type = T_I;
      end
      OPC_OP_IMM: begin
        dec.imm      = is_shift ? XLEN'(shamt) : sext({{20{i_instr[31]}}, i_instr[31:20]});
        dec.imm_type = T_I;
      end
      // Word-sized shifts only exist on RV64 and always carry a 5-bit shamt.
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          dec.imm      = is_shift ? XLEN'(i_instr[24:20]) : sext({{20{i_instr[31]}}, i_instr[31:20]});
          dec.imm_type = T_I;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        dec.imm      = sext({{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]});
        dec.imm_type = T_S;
      end
      OPC_BRANCH: begin
        dec.imm      = sext({{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0});
        dec.imm_type = T_B;
      end
      OPC_JAL: begin
        dec.imm      = sext({{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0});
        dec.imm_type = T_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm      = sext({i_instr[31:12], 12'h000});
        dec.imm_type = T_U;
      end
      OPC_SYSTEM: begin
        if (EN_ZICSR && i_instr[14]) begin
          dec.imm      = XLEN'(i_instr[19:15]);
          dec.imm_type = T_Z;
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
      end
      OPC_OP32: dec.illegal = (XLEN != 64);
      default:  dec.illegal = 1'b1;
    endcase
  end

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = (state != S_EMPTY) && i_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (out_xfer) begin
            state_nxt = S_EMPTY;
          end else if (in_xfer) begin
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != S_FULL);
      if (i_flush) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main_in) begin
          main_q <= dec;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= dec;
        end
      end
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = (state != S_EMPTY);
  assign o_instr     = main_q.instr;
  assign o_imm       = main_q.imm;
  assign o_imm_type  = main_q.imm_type;
  assign o_illegal   = main_q.illegal;
  assign o_dbg_state = state;

endmodule
